// File: rtl/window_buffer_3x3_pkg.sv
// Shared image geometry and pixel type for the canny pipeline blocks.
// IM_WIDTH / IM_HEIGHT may be predefined by the build; otherwise VGA defaults apply.
// Related build option: WINBUF_FRAME_FLAGS_EN (frame flags in window_buffer_3x3).
`ifndef IM_WIDTH
`define IM_WIDTH 640
`endif
`ifndef IM_HEIGHT
`define IM_HEIGHT 480
`endif

package window_buffer_3x3_pkg;

  localparam int IM_WIDTH   = `IM_WIDTH;
  localparam int IM_HEIGHT  = `IM_HEIGHT;
  localparam int PIXEL_BITS = 8;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_buffer_3x3_if.sv
// Pixel-in / window-out handshake bundle of window_buffer_3x3.
// slave = the window buffer, master = the side feeding pixels and taking windows.
interface window_buffer_3x3_if
  import window_buffer_3x3_pkg::*;
#(
  parameter int NBIT        = $bits(pixel_t),
  parameter int KERNEL_SIZE = 3
);

  logic [NBIT-1:0] i_pixel;
  logic            i_pixel_valid;
  logic            o_pixel_ready;
  logic [NBIT-1:0] o_window [KERNEL_SIZE][KERNEL_SIZE];
  logic            o_window_valid;
  logic            i_window_ready;
  logic            o_frame_start;
  logic            o_frame_end;

  modport master (
    output i_pixel, i_pixel_valid, i_window_ready,
    input  o_pixel_ready, o_window, o_window_valid, o_frame_start, o_frame_end
  );

  modport slave (
    input  i_pixel, i_pixel_valid, i_window_ready,
    output o_pixel_ready, o_window, o_window_valid, o_frame_start, o_frame_end
  );

endinterface

// File: rtl/window_buffer_3x3_line_buffer.sv
// One image row of storage. The read port is combinational, so the value seen
// at a column during an enabled cycle is the one written a row earlier; the
// new value lands at the clock edge. Contents are deliberately not reset.
module line_buffer
  import window_buffer_3x3_pkg::*;
#(
  parameter int NBIT  = $bits(pixel_t),
  parameter int DEPTH = IM_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_en,
  input  logic [cnt_width(DEPTH)-1:0] i_addr,
  input  logic [NBIT-1:0]             i_din,
  output logic [NBIT-1:0]             o_dout
);

  logic [NBIT-1:0] mem [DEPTH];

  assign o_dout = mem[i_addr];

  // overwrite the column only after its previous-row value has been read out
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem[i_addr] <= i_din;
    end
  end

endmodule

// File: rtl/window_buffer_3x3.sv
// Sliding KxK window generator over a raster pixel stream (valid-mode, no padding).
// Build option WINBUF_FRAME_FLAGS_EN: when defined, o_frame_start / o_frame_end mark
// the first and last window of each frame; when undefined both are tied low.
module window_buffer_3x3
  import window_buffer_3x3_pkg::*;
#(
  parameter int NBIT         = $bits(pixel_t),
  parameter int KERNEL_SIZE  = 3,
  parameter int IMAGE_WIDTH  = `IM_WIDTH,
  parameter int IMAGE_HEIGHT = `IM_HEIGHT
) (
  input logic                i_clk,
  input logic                i_rst_n,
  window_buffer_3x3_if.slave bus
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = cnt_width(IMAGE_WIDTH);
  localparam int RW = cnt_width(IMAGE_HEIGHT);

  localparam logic [CW-1:0] C_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] R_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            pixel_ready;
  logic            accept;
  logic            produce;
  logic            win_valid_q;

  // column[x] is the pixel of row (r-K+1+x) at the current column
  logic [NBIT-1:0] column   [K];
  logic [NBIT-1:0] lb_din   [K-1];
  logic [NBIT-1:0] lb_out   [K-1];
  // the K-1 most recent columns of the current row band, oldest first
  logic [NBIT-1:0] shift_q  [K][K-1];
  logic [NBIT-1:0] win_next [K][K];
  logic [NBIT-1:0] win_q    [K][K];

  assign pixel_ready = !win_valid_q || bus.i_window_ready;
  assign accept      = bus.i_pixel_valid && pixel_ready;
  // stale columns/rows from a previous row or frame never qualify here
  assign produce     = accept && (row_q >= R_FIRST) && (col_q >= C_FIRST);

  assign bus.o_pixel_ready  = pixel_ready;
  assign bus.o_window_valid = win_valid_q;
  assign bus.o_window       = win_q;

  assign column[K-1] = bus.i_pixel;

  // Line buffers are chained: buffer 0 holds row r-1, buffer i holds row r-1-i.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
    if (gi == 0) begin : g_head
      assign lb_din[gi] = bus.i_pixel;
    end else begin : g_tail
      assign lb_din[gi] = lb_out[gi-1];
    end

    assign column[K-2-gi] = lb_out[gi];

    line_buffer #(
      .NBIT  (NBIT),
      .DEPTH (IMAGE_WIDTH)
    ) u_line_buffer (
      .i_clk  (i_clk),
      .i_en   (accept),
      .i_addr (col_q),
      .i_din  (lb_din[gi]),
      .o_dout (lb_out[gi])
    );
  end

  // raster position of the next pixel to be accepted
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == C_LAST) begin
        col_q <= '0;
        row_q <= (row_q == R_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // window as it looks once the incoming column is shifted in
  always_comb begin
    for (int x = 0; x < K; x++) begin
      for (int y = 0; y < K - 1; y++) begin
        win_next[x][y] = shift_q[x][y];
      end
      win_next[x][K-1] = column[x];
    end
  end

  // keep the newest K-1 columns; data path only, no reset needed
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int x = 0; x < K; x++) begin
        for (int y = 0; y < K - 1; y++) begin
          shift_q[x][y] <= win_next[x][y+1];
        end
      end
    end
  end

  // output register: load on a qualifying accept, hold while stalled, drop after handshake
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      win_valid_q <= 1'b0;
      win_q       <= '{default: '0};
    end else if (produce) begin
      win_valid_q <= 1'b1;
      win_q       <= win_next;
    end else if (bus.i_window_ready) begin
      win_valid_q <= 1'b0;
    end
  end

`ifdef WINBUF_FRAME_FLAGS_EN
  logic frame_start_q;
  logic frame_end_q;

  // flags travel with the window they describe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else if (produce) begin
      frame_start_q <= (row_q == R_FIRST) && (col_q == C_FIRST);
      frame_end_q   <= (row_q == R_LAST) && (col_q == C_LAST);
    end else if (bus.i_window_ready) begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end
  end

  assign bus.o_frame_start = frame_start_q;
  assign bus.o_frame_end   = frame_end_q;
`else
  assign bus.o_frame_start = 1'b0;
  assign bus.o_frame_end   = 1'b0;
`endif

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Bench for window_buffer_3x3 at W=8, H=6, K=3 with pixel value r*16+c.
module tb_window_buffer_3x3;

  localparam int NB = 8;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int KK = K * K;
  localparam int NWIN = (H - K + 1) * (W - K + 1);

`ifdef WINBUF_FRAME_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [KK*NB-1:0] win;
    logic             fs;
    logic             fe;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_buffer_3x3_if #(.NBIT(NB), .KERNEL_SIZE(K)) wb_if ();

  window_buffer_3x3 #(
    .NBIT         (NB),
    .KERNEL_SIZE  (K),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (wb_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t mon_rec;

  function automatic logic [NB-1:0] pix_at(input int r, input int c);
    return NB'(r * 16 + c);
  endfunction

  function automatic logic [KK*NB-1:0] dut_window();
    logic [KK*NB-1:0] v;
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        v[(x*K+y)*NB +: NB] = wb_if.o_window[x][y];
    return v;
  endfunction

  // reference: every valid-mode window of the image, in raster order of its bottom-right pixel
  function automatic void build_expected(input int nframes);
    rec_t e;
    exp_q.delete();
    for (int f = 0; f < nframes; f++)
      for (int r = K - 1; r < H; r++)
        for (int c = K - 1; c < W; c++) begin
          for (int x = 0; x < K; x++)
            for (int y = 0; y < K; y++)
              e.win[(x*K+y)*NB +: NB] = pix_at(r - K + 1 + x, c - K + 1 + y);
          e.fs = FLAGS_EN && (r == K - 1) && (c == K - 1);
          e.fe = FLAGS_EN && (r == H - 1) && (c == W - 1);
          exp_q.push_back(e);
        end
  endfunction

  // capture every window consumed by a handshake
  always @(negedge clk) begin
    if (rst_n && wb_if.o_window_valid && wb_if.i_window_ready) begin
      mon_rec.win = dut_window();
      mon_rec.fs  = wb_if.o_frame_start;
      mon_rec.fe  = wb_if.o_frame_end;
      got_q.push_back(mon_rec);
    end
  end

  // offers pixels 0..count-1 of the raster stream; starts and ends 1 time unit after a rising edge
  task automatic drive_pixels(input int count, input int pct);
    int idx = 0;
    int cycles = 0;
    while (idx < count && cycles < count * 20 + 200) begin
      wb_if.i_pixel       = pix_at((idx / W) % H, idx % W);
      wb_if.i_pixel_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      if (wb_if.i_pixel_valid && wb_if.o_pixel_ready) idx++;
      @(posedge clk); #1;
      cycles++;
    end
    wb_if.i_pixel_valid = 1'b0;
    n_checks++;
    if (idx !== count) begin
      n_fail++;
      $display("FAIL drive_accept: accepted %0d pixels, required %0d", idx, count);
    end
  endtask

  task automatic drain();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (wb_if.o_window_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, required 0", wb_if.o_window_valid);
    end
    n_checks++;
    if (dut_window() !== '0) begin
      n_fail++; $display("FAIL reset_window: got %h, required 0", dut_window());
    end
    n_checks++;
    if (wb_if.o_frame_start !== 1'b0 || wb_if.o_frame_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got fs=%b fe=%b, required 0 0", wb_if.o_frame_start, wb_if.o_frame_end);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wb_if.o_pixel_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_pixel_ready: got %b, required 1", wb_if.o_pixel_ready);
    end
  endtask

  task automatic test_continuous();
    build_expected(1);
    got_q.delete();
    wb_if.i_window_ready = 1'b1;
    fork
      drive_pixels(W * H, 100);
      begin : latency
        int  g;
        bit  seen;
        g = 0;
        seen = 1'b0;
        while (!seen && g < 200) begin
          @(negedge clk);
          g++;
          if (wb_if.i_pixel_valid && wb_if.o_pixel_ready && wb_if.i_pixel == 8'h22) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
          n_fail++; $display("FAIL cont_latency_wait: pixel (2,2) never accepted, required acceptance");
        end else begin
          if (wb_if.o_window_valid !== 1'b0) begin
            n_fail++; $display("FAIL cont_latency_early: valid=%b before first window, required 0", wb_if.o_window_valid);
          end
          @(negedge clk);
          n_checks++;
          if (wb_if.o_window_valid !== 1'b1) begin
            n_fail++; $display("FAIL cont_latency: valid=%b one cycle after (2,2), required 1", wb_if.o_window_valid);
          end
        end
      end
    join
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL cont_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL cont_window[%0d]: got %h fs=%b fe=%b, required %h fs=%b fe=%b",
                 i, got_q[i].win, got_q[i].fs, got_q[i].fe, exp_q[i].win, exp_q[i].fs, exp_q[i].fe);
      end
    end
    if (got_q.size() == NWIN) begin
      n_checks++;
      if (got_q[0].win[0 +: NB] !== 8'h00 || got_q[0].win[8*NB +: NB] !== 8'h22) begin
        n_fail++; $display("FAIL cont_first: got [0][0]=%h [2][2]=%h, required 00 22",
                           got_q[0].win[0 +: NB], got_q[0].win[8*NB +: NB]);
      end
      n_checks++;
      if (got_q[NWIN-1].win[8*NB +: NB] !== 8'h57) begin
        n_fail++; $display("FAIL cont_last: got [2][2]=%h, required 57", got_q[NWIN-1].win[8*NB +: NB]);
      end
    end
  endtask

  task automatic test_stall();
    build_expected(1);
    got_q.delete();
    wb_if.i_window_ready = 1'b0;
    fork
      drive_pixels(W * H, 100);
      begin : stall
        int               g;
        logic [KK*NB-1:0] snap;
        g = 0;
        while (wb_if.o_window_valid !== 1'b1 && g < 200) begin
          @(negedge clk);
          g++;
        end
        n_checks++;
        if (wb_if.o_window_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_wait: no window appeared, required one");
        end else begin
          snap = dut_window();
          for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (dut_window() !== snap || wb_if.o_window_valid !== 1'b1) begin
              n_fail++; $display("FAIL stall_hold[%0d]: got %h valid=%b, required %h valid=1",
                                 k, dut_window(), wb_if.o_window_valid, snap);
            end
            n_checks++;
            if (wb_if.o_pixel_ready !== 1'b0) begin
              n_fail++; $display("FAIL stall_pixel_ready[%0d]: got %b, required 0", k, wb_if.o_pixel_ready);
            end
          end
        end
        @(posedge clk); #1;
        wb_if.i_window_ready = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_window[%0d]: got %h fs=%b fe=%b, required %h fs=%b fe=%b",
                 i, got_q[i].win, got_q[i].fs, got_q[i].fe, exp_q[i].win, exp_q[i].fs, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_random_valid();
    build_expected(1);
    got_q.delete();
    wb_if.i_window_ready = 1'b1;
    drive_pixels(W * H, 50);
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_window[%0d]: got %h fs=%b fe=%b, required %h fs=%b fe=%b",
                 i, got_q[i].win, got_q[i].fs, got_q[i].fe, exp_q[i].win, exp_q[i].fs, exp_q[i].fe);
      end
    end
  endtask

  task automatic test_back_to_back();
    build_expected(2);
    got_q.delete();
    wb_if.i_window_ready = 1'b1;
    drive_pixels(2 * W * H, 100);
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_window[%0d]: got %h fs=%b fe=%b, required %h fs=%b fe=%b",
                 i, got_q[i].win, got_q[i].fs, got_q[i].fe, exp_q[i].win, exp_q[i].fs, exp_q[i].fe);
      end
    end
    if (got_q.size() == 2 * NWIN) begin
      n_checks++;
      if (got_q[NWIN].win !== got_q[0].win) begin
        n_fail++; $display("FAIL b2b_repeat: window 25 %h, required window 1 %h", got_q[NWIN].win, got_q[0].win);
      end
      n_checks++;
      if (got_q[0].fs !== FLAGS_EN || got_q[NWIN].fs !== FLAGS_EN || got_q[1].fs !== 1'b0) begin
        n_fail++; $display("FAIL b2b_frame_start: got w1=%b w2=%b w25=%b, required %b 0 %b",
                           got_q[0].fs, got_q[1].fs, got_q[NWIN].fs, FLAGS_EN, FLAGS_EN);
      end
      n_checks++;
      if (got_q[NWIN-1].fe !== FLAGS_EN || got_q[2*NWIN-1].fe !== FLAGS_EN || got_q[NWIN-2].fe !== 1'b0) begin
        n_fail++; $display("FAIL b2b_frame_end: got w23=%b w24=%b w48=%b, required 0 %b %b",
                           got_q[NWIN-2].fe, got_q[NWIN-1].fe, got_q[2*NWIN-1].fe, FLAGS_EN, FLAGS_EN);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    wb_if.i_window_ready = 1'b1;
    drive_pixels(3 * W + 4 + 1, 100);
    n_checks++;
    if (wb_if.o_window_valid !== 1'b1) begin
      n_fail++; $display("FAIL mreset_pre_valid: got %b after accepting (3,4), required 1", wb_if.o_window_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wb_if.o_window_valid !== 1'b0) begin
      n_fail++; $display("FAIL mreset_valid: got %b, required 0", wb_if.o_window_valid);
    end
    rst_n = 1'b1;
    got_q.delete();
    build_expected(1);
    drive_pixels(W * H, 100);
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL mreset_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mreset_window[%0d]: got %h fs=%b fe=%b, required %h fs=%b fe=%b",
                 i, got_q[i].win, got_q[i].fs, got_q[i].fe, exp_q[i].win, exp_q[i].fs, exp_q[i].fe);
      end
    end
  endtask

  initial begin
    wb_if.i_pixel        = '0;
    wb_if.i_pixel_valid  = 1'b0;
    wb_if.i_window_ready = 1'b1;
    test_reset();
    test_continuous();
    test_stall();
    test_random_valid();
    test_back_to_back();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
